// File: rtl/out_check_pkg.sv
// rtl/out_check_pkg.sv - state encoding and width defaults shared by the output channel checker
package out_check_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } check_state_e;

  localparam int DefaultWordW     = 12;
  localparam int DefaultNExpected = 8;
  localparam int DefaultFifoDepth = 4;
  localparam int AddrW            = $clog2(DefaultNExpected);
  localparam int CountW           = $clog2(DefaultNExpected + 1);

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/out_word_fifo.sv
// rtl/out_word_fifo.sv - synchronous word FIFO with wrap-bit pointers and a combinational head
module out_word_fifo #(
  parameter int Width = 12,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Equal indices with differing wrap bits means the writer has lapped the reader.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign head_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/out_channel_checker.sv
// rtl/out_channel_checker.sv - buffers emulator output words, forwards them downstream and checks them against a preloaded sequence
module out_channel_checker
  import out_check_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultWordW,
  parameter int NExpected          = DefaultNExpected,
  parameter int FifoDepth          = DefaultFifoDepth
) (
  input  logic                             clock,
  input  logic                             resetN,
  input  logic                             exp_we,
  input  logic [$clog2(NExpected)-1:0]     exp_addr,
  input  logic [MemoryElementWidth-1:0]    exp_data,
  input  logic [$clog2(NExpected+1)-1:0]   exp_count,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic [MemoryElementWidth-1:0]    in_data,
  output logic                             in_ready,
  input  logic                             in_done,
  output logic                             out_valid,
  output logic [MemoryElementWidth-1:0]    out_data,
  input  logic                             out_ready,
  output logic                             finished,
  output logic                             success,
  output logic                             mismatch,
  output logic [$clog2(NExpected+1)-1:0]   mismatch_index,
  output logic [$clog2(NExpected+1):0]     word_count
);

  localparam int W        = MemoryElementWidth;
  localparam int MemAddrW = $clog2(NExpected);
  localparam int CntW     = count_width(NExpected);
  localparam logic [CntW:0] NExpectedW = (CntW+1)'(NExpected);

  check_state_e    state_q, state_d;
  logic            done_q, done_d;
  logic [CntW-1:0] exp_count_q, exp_count_d;
  logic [CntW:0]   word_count_q, word_count_d;
  logic            mismatch_q, mismatch_d;
  logic [CntW-1:0] mismatch_index_q, mismatch_index_d;

  logic [W-1:0]    exp_mem_q [NExpected];
  logic            fifo_full, fifo_empty;
  logic [W-1:0]    fifo_head, expected_word;
  logic            push, pop, in_range, word_differs;

  out_word_fifo #(
    .Width (W),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (resetN),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign in_ready  = (state_q == CHECK) && !fifo_full;
  assign push      = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign pop       = out_valid && out_ready;

  assign finished       = (state_q == DONE);
  assign success        = finished && !mismatch_q && (word_count_q == {1'b0, exp_count_q});
  assign mismatch       = mismatch_q;
  assign mismatch_index = mismatch_index_q;
  assign word_count     = word_count_q;

  // Words beyond exp_count (or beyond the memory) count as mismatches.
  assign expected_word = exp_mem_q[word_count_q[MemAddrW-1:0]];
  assign in_range      = (word_count_q < {1'b0, exp_count_q}) && (word_count_q < NExpectedW);
  assign word_differs  = !in_range || (fifo_head != expected_word);

  always_ff @(posedge clock) begin
    if (exp_we && (state_q == LOAD)) begin
      exp_mem_q[exp_addr] <= exp_data;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q          <= LOAD;
      done_q           <= 1'b0;
      exp_count_q      <= '0;
      word_count_q     <= '0;
      mismatch_q       <= 1'b0;
      mismatch_index_q <= '0;
    end else begin
      state_q          <= state_d;
      done_q           <= done_d;
      exp_count_q      <= exp_count_d;
      word_count_q     <= word_count_d;
      mismatch_q       <= mismatch_d;
      mismatch_index_q <= mismatch_index_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    done_d           = done_q;
    exp_count_d      = exp_count_q;
    word_count_d     = word_count_q;
    mismatch_d       = mismatch_q;
    mismatch_index_d = mismatch_index_q;

    if (pop) begin
      if (word_differs && !mismatch_q) begin
        mismatch_d       = 1'b1;
        mismatch_index_d = word_count_q[CntW-1:0];
      end
      if (word_count_q != '1) begin
        word_count_d = word_count_q + (CntW+1)'(1);
      end
    end

    case (state_q)
      LOAD, DONE: begin
        if (start) begin
          state_d          = CHECK;
          done_d           = 1'b0;
          exp_count_d      = exp_count;
          word_count_d     = '0;
          mismatch_d       = 1'b0;
          mismatch_index_d = '0;
        end
      end
      CHECK: begin
        if (in_done) begin
          done_d = 1'b1;
        end
        // Wait for the last accepted word to be popped and scored.
        if (done_q && fifo_empty) begin
          state_d = DONE;
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// tb/tb_out_channel_checker.sv - directed vector bench for out_channel_checker
module tb_out_channel_checker;

  logic        clock;
  logic        resetN;
  logic        exp_we;
  logic [2:0]  exp_addr;
  logic [11:0] exp_data;
  logic [3:0]  exp_count;
  logic        start;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ready;
  logic        in_done;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_ready;
  logic        finished;
  logic        success;
  logic        mismatch;
  logic [3:0]  mismatch_index;
  logic [4:0]  word_count;

  out_channel_checker #(
    .MemoryElementWidth (12),
    .NExpected          (8),
    .FifoDepth          (4)
  ) dut (
    .clock          (clock),
    .resetN         (resetN),
    .exp_we         (exp_we),
    .exp_addr       (exp_addr),
    .exp_data       (exp_data),
    .exp_count      (exp_count),
    .start          (start),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .in_done        (in_done),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .finished       (finished),
    .success        (success),
    .mismatch       (mismatch),
    .mismatch_index (mismatch_index),
    .word_count     (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic         ld;
    logic [95:0]  exp_w;
    logic [3:0]   exp_n;
    logic [119:0] push_w;
    logic [3:0]   push_n;
    logic         succ;
    logic         mism;
    logic [3:0]   idx;
    logic [4:0]   wc;
  } vec_t;

  vec_t        vecs [10];
  logic [11:0] sink [$];
  int          n_cmp;
  int          n_fail;
  int          k;
  logic        acc;

  // Records each word that will be popped on the coming rising edge.
  always @(negedge clock) begin
    #2;
    if (resetN && out_valid && out_ready) sink.push_back(out_data);
  end

  function automatic vec_t mk(input logic ld, input logic [95:0] e, input logic [3:0] en,
                              input logic [119:0] p, input logic [3:0] pn, input logic s,
                              input logic m, input logic [3:0] ix, input logic [4:0] wc);
    vec_t v;
    v.ld = ld; v.exp_w = e; v.exp_n = en; v.push_w = p; v.push_n = pn;
    v.succ = s; v.mism = m; v.idx = ix; v.wc = wc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0; exp_we = 1'b0; start = 1'b0; in_valid = 1'b0; in_done = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic load_mem(input logic [95:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      exp_we = 1'b1; exp_addr = 3'(i); exp_data = w[i*12 +: 12];
      @(negedge clock);
    end
    exp_we = 1'b0;
  endtask

  task automatic start_check(input logic [3:0] n);
    exp_count = n; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic push_word(input logic [11:0] d, input logic with_done);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_done = with_done;
    for (int n = 0; n < 50; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    in_valid = 1'b0; in_done = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic pulse_done();
    in_done = 1'b1;
    @(negedge clock);
    in_done = 1'b0;
  endtask

  task automatic wait_finished(input string name);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (finished) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk({name, "_finish_in_time"}, 32'(ok), 32'd1);
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    string nm;
    v = vecs[vi];
    nm = $sformatf("v%0d", vi);
    if (v.ld) begin
      do_reset();
      load_mem(v.exp_w, int'(v.exp_n));
    end
    sink.delete();
    out_ready = 1'b1;
    start_check(v.exp_n);
    for (int j = 0; j < int'(v.push_n); j++) begin
      push_word(v.push_w[j*12 +: 12], (j == int'(v.push_n) - 1));
    end
    if (v.push_n == 4'd0) pulse_done();
    wait_finished(nm);
    chk({nm, "_success"}, 32'(success), 32'(v.succ));
    chk({nm, "_mismatch"}, 32'(mismatch), 32'(v.mism));
    chk({nm, "_mismatch_index"}, 32'(mismatch_index), 32'(v.idx));
    chk({nm, "_word_count"}, 32'(word_count), 32'(v.wc));
    chk({nm, "_in_ready_done"}, 32'(in_ready), 32'd0);
    chk({nm, "_forwarded_count"}, 32'(sink.size()), 32'(v.push_n));
    if (sink.size() == int'(v.push_n)) begin
      for (int j = 0; j < int'(v.push_n); j++) begin
        chk({nm, "_forwarded_data"}, 32'(sink[j]), 32'(v.push_w[j*12 +: 12]));
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    resetN = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_count = '0;
    start = 1'b0; in_valid = 1'b0; in_data = '0; in_done = 1'b0; out_ready = 1'b0;

    vecs[0] = mk(1'b1, 96'(12'h005), 4'd1, 120'(12'h005), 4'd1, 1'b1, 1'b0, 4'd0, 5'd1);
    vecs[1] = mk(1'b1, 96'({12'h009, 12'h007, 12'h005}), 4'd3,
                 120'({12'h008, 12'h006, 12'h005}), 4'd3, 1'b0, 1'b1, 4'd1, 5'd3);
    vecs[2] = mk(1'b0, 96'({12'h009, 12'h007, 12'h005}), 4'd3,
                 120'({12'h009, 12'h007, 12'h005}), 4'd3, 1'b1, 1'b0, 4'd0, 5'd3);
    vecs[3] = mk(1'b1, 96'({12'h004, 12'h003}), 4'd2, 120'(12'h003), 4'd1,
                 1'b0, 1'b0, 4'd0, 5'd1);
    vecs[4] = mk(1'b1, 96'({12'h004, 12'h003}), 4'd2,
                 120'({12'h004, 12'h004, 12'h003}), 4'd3, 1'b0, 1'b1, 4'd2, 5'd3);
    vecs[5] = mk(1'b1, 96'({12'h123, 12'h000, 12'h800, 12'hFFF}), 4'd4,
                 120'({12'h123, 12'h000, 12'h800, 12'hFFF}), 4'd4, 1'b1, 1'b0, 4'd0, 5'd4);
    vecs[6] = mk(1'b1, 96'(12'h800), 4'd1, 120'(12'h000), 4'd1, 1'b0, 1'b1, 4'd0, 5'd1);
    vecs[7] = mk(1'b1, 96'd0, 4'd0, 120'd0, 4'd0, 1'b1, 1'b0, 4'd0, 5'd0);
    vecs[8] = mk(1'b1, 96'd0, 4'd0, 120'(12'h0A5), 4'd1, 1'b0, 1'b1, 4'd0, 5'd1);
    vecs[9] = mk(1'b1, 96'({12'h888, 12'h777, 12'h666, 12'h555, 12'h444, 12'h333, 12'h222, 12'h111}), 4'd8,
                 120'({12'h880, 12'h777, 12'h666, 12'h555, 12'h444, 12'h333, 12'h222, 12'h111}), 4'd8,
                 1'b0, 1'b1, 4'd7, 5'd8);

    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_success", 32'(success), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_mismatch_index", 32'(mismatch_index), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    resetN = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Backpressure: four words fill the FIFO, the fifth waits; exp_we in CHECK must not land.
    do_reset();
    load_mem(96'({12'd5, 12'd4, 12'd3, 12'd2, 12'd1}), 5);
    sink.delete();
    out_ready = 1'b0;
    start_check(4'd5);
    exp_we = 1'b1; exp_addr = 3'd0; exp_data = 12'hABC;
    k = 1;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data = 12'(k); acc = in_ready;
      @(negedge clock);
      if (acc) k++;
    end
    exp_we = 1'b0;
    chk("bp_accepted_before_stall", 32'(k), 32'd5);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && k <= 5; c++) begin
      in_data = 12'(k); acc = in_ready;
      @(negedge clock);
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_fifth_accepted", 32'(k), 32'd6);
    pulse_done();
    wait_finished("bp");
    chk("bp_forwarded_count", 32'(sink.size()), 32'd5);
    if (sink.size() == 5) begin
      for (int j = 0; j < 5; j++) chk("bp_order", 32'(sink[j]), 32'(j + 1));
    end
    chk("bp_success", 32'(success), 32'd1);
    chk("bp_word_count", 32'(word_count), 32'd5);

    // in_done arrives while two words are still buffered.
    do_reset();
    load_mem(96'({12'd8, 12'd7}), 2);
    out_ready = 1'b0;
    start_check(4'd2);
    push_word(12'd7, 1'b0);
    chk("dd_out_valid_next_cycle", 32'(out_valid), 32'd1);
    chk("dd_head", 32'(out_data), 32'd7);
    push_word(12'd8, 1'b0);
    pulse_done();
    repeat (4) @(negedge clock);
    chk("dd_not_finished_while_buffered", 32'(finished), 32'd0);
    out_ready = 1'b1;
    @(negedge clock);
    chk("dd_not_finished_one_left", 32'(finished), 32'd0);
    @(negedge clock);
    chk("dd_drained", 32'(out_valid), 32'd0);
    chk("dd_not_finished_at_drain", 32'(finished), 32'd0);
    @(negedge clock);
    chk("dd_finished", 32'(finished), 32'd1);
    chk("dd_success", 32'(success), 32'd1);
    chk("dd_word_count", 32'(word_count), 32'd2);

    // Asynchronous reset in the middle of a cycle with words buffered.
    do_reset();
    load_mem(96'(12'd5), 1);
    out_ready = 1'b0;
    start_check(4'd1);
    push_word(12'd5, 1'b0);
    push_word(12'd6, 1'b0);
    #3;
    resetN = 1'b0;
    #1;
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data", 32'(out_data), 32'd0);
    chk("mr_finished", 32'(finished), 32'd0);
    chk("mr_word_count", 32'(word_count), 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
